// File: rtl/sram_ctrl_if.sv
// rtl/sram_ctrl_if.sv - request/response bundle between the memory stage and sram_ctrl
// master = core/LSU side, slave = controller side.
interface sram_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_WIDTH = ADDR_WIDTH / 8;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [BE_WIDTH-1:0]   req_be;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_be, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_be, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - single-outstanding initiator for an asynchronous SRAM bus
// Optional misaligned-address rejection under `SRAM_CTRL_ALIGN_CHK_EN.
module sram_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int WR_PULSE   = 2,
  parameter int RD_WAIT    = 2,
  localparam int BE_WIDTH  = ADDR_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sram_ctrl_if.slave            bus,
  output logic                  sram_cs_n,
  output logic                  sram_oe_n,
  output logic                  sram_wr_n,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [BE_WIDTH-1:0]   sram_size,
  inout  wire  [DATA_WIDTH-1:0] sram_data
);
  typedef enum logic [2:0] {
    IDLE, WSETUP, WPULSE, WHOLD, RSETUP, RWAIT, DONE
  } state_t;

  localparam logic [7:0] WP_LAST = 8'(WR_PULSE - 1);
  localparam logic [7:0] RW_LAST = 8'(RD_WAIT - 1);

  state_t                state, nstate;
  logic [7:0]            cnt, cnt_n;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  accept, capture, err_n, drive;

  // The data bus is only ever driven from the three write states, so a read
  // (oe_n low) can never overlap it.
  assign drive     = (state == WSETUP) || (state == WPULSE) || (state == WHOLD);
  assign sram_data = drive ? wdata_q : {DATA_WIDTH{1'bz}};

  always_comb begin
    nstate  = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    capture = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid && bus.req_ready) begin
          accept = 1'b1;
          nstate = bus.req_we ? WSETUP : RSETUP;
`ifdef SRAM_CTRL_ALIGN_CHK_EN
          if (|bus.req_addr[$clog2(BE_WIDTH)-1:0]) begin
            err_n  = 1'b1;
            nstate = DONE;
          end
`endif
        end
      end
      WSETUP: begin
        nstate = WPULSE;
        cnt_n  = WP_LAST;
      end
      WPULSE: begin
        if (cnt == 8'd0) nstate = WHOLD;
        else             cnt_n  = cnt - 8'd1;
      end
      WHOLD:  nstate = DONE;
      RSETUP: begin
        nstate = RWAIT;
        cnt_n  = RW_LAST;
      end
      RWAIT: begin
        if (cnt == 8'd0) begin
          nstate  = DONE;
          capture = 1'b1;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they change cleanly on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= 8'd0;
      wdata_q        <= '0;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      bus.resp_rdata <= '0;
      sram_cs_n      <= 1'b1;
      sram_oe_n      <= 1'b1;
      sram_wr_n      <= 1'b1;
      sram_addr      <= '0;
      sram_size      <= '0;
    end else begin
      state <= nstate;
      cnt   <= cnt_n;
      if (accept) begin
        sram_addr <= bus.req_addr;
        sram_size <= bus.req_be;
        wdata_q   <= bus.req_wdata;
      end
      if (capture) bus.resp_rdata <= sram_data;
      bus.req_ready  <= (nstate == IDLE);
      bus.resp_valid <= (nstate == DONE);
      bus.resp_err   <= err_n;
      sram_cs_n <= !((nstate == WSETUP) || (nstate == WPULSE) || (nstate == WHOLD) ||
                     (nstate == RSETUP) || (nstate == RWAIT));
      sram_oe_n <= !((nstate == RSETUP) || (nstate == RWAIT));
      sram_wr_n <= !(nstate == WPULSE);
    end
  end
endmodule

// File: tb/tb_sram_ctrl.sv
// tb/tb_sram_ctrl.sv - directed self-checking bench for sram_ctrl
// Includes a byte-lane SRAM model that commits on the rising edge of sram_wr_n.
module tb_sram_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  logic        sram_cs_n, sram_oe_n, sram_wr_n;
  logic [31:0] sram_addr;
  logic [3:0]  sram_size;
  tri1  [31:0] sram_data;

  sram_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .WR_PULSE(2), .RD_WAIT(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .sram_cs_n(sram_cs_n), .sram_oe_n(sram_oe_n), .sram_wr_n(sram_wr_n),
    .sram_addr(sram_addr), .sram_size(sram_size), .sram_data(sram_data)
  );

  logic [31:0] mem [256];
  assign sram_data = (!sram_cs_n && !sram_oe_n) ? mem[sram_addr[9:2]] : 32'hzzzz_zzzz;

  always @(posedge sram_wr_n) begin
    if (!sram_cs_n)
      for (int i = 0; i < 4; i++)
        if (sram_size[i]) mem[sram_addr[9:2]][8*i +: 8] = sram_data[8*i +: 8];
  end

  int n_checks = 0;
  int n_pass   = 0;
  int viol     = 0;
  int hiz_viol = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Read strobe must never coincide with a write strobe or a foreign driver,
  // and an idle bus must float.
  always @(negedge clk) begin
    if (!sram_oe_n && (!sram_wr_n || sram_data !== mem[sram_addr[9:2]])) viol++;
    if (sram_cs_n && sram_data !== 32'hFFFF_FFFF) hiz_viol++;
  end

  int          t_resp;
  logic [15:0] t_wr, t_oe, t_cs;
  logic [31:0] t_rdata;
  logic        t_err, t_rdy;

  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd);
    t_resp = -1; t_wr = '0; t_oe = '0; t_cs = '0; t_rdata = '0; t_err = 1'b0; t_rdy = 1'b1;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr;
    bus.req_be = be; bus.req_wdata = wd;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 1) bus.req_valid = 1'b0;
      t_wr[c] = !sram_wr_n;
      t_oe[c] = !sram_oe_n;
      t_cs[c] = !sram_cs_n;
      if (bus.resp_valid && t_resp < 0) begin
        t_resp = c; t_rdata = bus.resp_rdata; t_err = bus.resp_err; t_rdy = bus.req_ready;
      end
    end
  endtask

  int acc [4];
  int rsp [4];
  int na, nr, seen;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
    bus.req_be = '0; bus.req_wdata = '0;

    // 1: reset then idle
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(sram_cs_n), 32'd1);
    check("rst_oe_n", 32'(sram_oe_n), 32'd1);
    check("rst_wr_n", 32'(sram_wr_n), 32'd1);
    check("rst_data_hiz", sram_data, 32'hFFFF_FFFF);
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_rdata", bus.resp_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 2: full write then read
    run_txn(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF);
    check("wr_resp_cycle", 32'(t_resp), 32'd5);
    check("wr_wr_n_low_mask", 32'(t_wr), 32'h000C);
    check("wr_cs_n_low_mask", 32'(t_cs), 32'h001E);
    check("wr_oe_n_low_mask", 32'(t_oe), 32'h0000);
    check("wr_err", 32'(t_err), 32'd0);
    check("wr_ready_in_done", 32'(t_rdy), 32'd0);
    check("wr_mem", mem[4], 32'hDEAD_BEEF);
    run_txn(1'b0, 32'h10, 4'hF, 32'h0);
    check("rd_resp_cycle", 32'(t_resp), 32'd4);
    check("rd_oe_n_low_mask", 32'(t_oe), 32'h000E);
    check("rd_wr_n_low_mask", 32'(t_wr), 32'h0000);
    check("rd_rdata", t_rdata, 32'hDEAD_BEEF);

    // 3: byte-lane write, then empty mask write
    mem[8] = 32'h1122_3344;
    run_txn(1'b1, 32'h20, 4'b0010, 32'h0000_AA00);
    run_txn(1'b0, 32'h20, 4'hF, 32'h0);
    check("lane_rdata", t_rdata, 32'h1122_AA44);
    run_txn(1'b1, 32'h20, 4'b0000, 32'hFFFF_FFFF);
    check("be0_resp_cycle", 32'(t_resp), 32'd5);
    check("be0_mem", mem[8], 32'h1122_AA44);
    check("be0_rdata_held", bus.resp_rdata, 32'h1122_AA44);

    // 4: back-to-back with req_valid held high
    na = 0; nr = 0;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h40;
    bus.req_be = 4'hF; bus.req_wdata = 32'hCAFE_F00D;
    for (int c = 0; c < 20; c++) begin
      if (bus.resp_valid && nr < 4) begin rsp[nr] = c; nr++; end
      if (bus.req_valid && bus.req_ready && na < 4) begin acc[na] = c; na++; end
      @(posedge clk); #1;
      if (na == 1) begin bus.req_we = 1'b0; bus.req_wdata = 32'h0; end
      if (na == 2) bus.req_valid = 1'b0;
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    check("b2b_accepts", 32'(na), 32'd2);
    check("b2b_second_accept", 32'(acc[1]), 32'd6);
    check("b2b_responses", 32'(nr), 32'd2);
    check("b2b_second_resp", 32'(rsp[1]), 32'd10);
    check("b2b_rdata", bus.resp_rdata, 32'hCAFE_F00D);

    // 5: reset during WPULSE
    seen = 0;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h30;
    bus.req_be = 4'hF; bus.req_wdata = 32'h5555_5555;
    @(negedge clk); bus.req_valid = 1'b0;
    @(negedge clk);
    check("pre_abort_wr_n", 32'(sram_wr_n), 32'd0);
    rst_n = 1'b0;
    #1;
    check("abort_cs_n", 32'(sram_cs_n), 32'd1);
    check("abort_wr_n", 32'(sram_wr_n), 32'd1);
    check("abort_oe_n", 32'(sram_oe_n), 32'd1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 2) rst_n = 1'b1;
      if (bus.resp_valid) seen++;
    end
    check("abort_no_resp", 32'(seen), 32'd0);
    mem[5] = 32'h0BAD_CAFE;
    run_txn(1'b0, 32'h14, 4'hF, 32'h0);
    check("post_abort_resp_cycle", 32'(t_resp), 32'd4);
    check("post_abort_rdata", t_rdata, 32'h0BAD_CAFE);

    // 6: misaligned write
    run_txn(1'b1, 32'h12, 4'hF, 32'h1234_5678);
`ifdef SRAM_CTRL_ALIGN_CHK_EN
    check("misalign_resp_cycle", 32'(t_resp), 32'd1);
    check("misalign_err", 32'(t_err), 32'd1);
    check("misalign_cs_n_low_mask", 32'(t_cs), 32'h0000);
    check("misalign_mem", mem[4], 32'hDEAD_BEEF);
`else
    check("misalign_resp_cycle", 32'(t_resp), 32'd5);
    check("misalign_err", 32'(t_err), 32'd0);
    check("misalign_mem", mem[4], 32'h1234_5678);
`endif

    check("bus_contention", 32'(viol), 32'd0);
    check("idle_bus_hiz", 32'(hiz_viol), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
